// File: rtl/wb_arbiter_2m_if.sv
// Bundle of the two requesting Wishbone ports and the shared downstream bus.
// The arbiter uses the master modport; the surrounding masters/slave use the slave modport.
interface wb_arbiter_2m_if;
  logic [1:0]  m_cyc_i;
  logic [1:0]  m_stb_i;
  logic [1:0]  m_we_i;
  logic [63:0] m_adr_i;
  logic [63:0] m_dat_i;
  logic [7:0]  m_sel_i;
  logic [5:0]  m_cti_i;
  logic [3:0]  m_bte_i;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_err_o;
  logic [1:0]  m_rty_o;
  logic [63:0] m_dat_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_ack_i;
  logic        s_err_i;
  logic        s_rty_i;
  logic [31:0] s_dat_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    output s_ack_i, s_err_i, s_rty_i, s_dat_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on ties, no preemption, and a
// watchdog that forces a bus error on the owner when its strobe goes unanswered.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  wb_arbiter_2m_if.master bus,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             w_last_grant_nxt;
  logic [CNT_W-1:0] r_wd_cnt;
  logic [CNT_W-1:0] w_wd_cnt_nxt;
  logic             w_own0;
  logic             w_own1;
  logic             w_term;
  logic             w_stall;
  logic             w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_wd_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
    end
  end

  // Grant decision is made only in IDLE, so a released port always sees one idle cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (bus.m_cyc_i == 2'b11) begin
          w_state_nxt      = r_last_grant ? ST_OWN0 : ST_OWN1;
          w_last_grant_nxt = ~r_last_grant;
        end else if (bus.m_cyc_i[0]) begin
          w_state_nxt      = ST_OWN0;
          w_last_grant_nxt = 1'b0;
        end else if (bus.m_cyc_i[1]) begin
          w_state_nxt      = ST_OWN1;
          w_last_grant_nxt = 1'b1;
        end
      end
      ST_OWN0: if (!bus.m_cyc_i[0]) w_state_nxt = ST_IDLE;
      ST_OWN1: if (!bus.m_cyc_i[1]) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_own0  = (r_state == ST_OWN0);
  assign w_own1  = (r_state == ST_OWN1);
  assign grant_o = {w_own1, w_own0};

  // Owner's fields onto the shared bus; cyc/stb follow the owner's cyc combinationally.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = '0;
    bus.s_bte_o = '0;
    if (w_own0) begin
      bus.s_cyc_o = bus.m_cyc_i[0];
      bus.s_stb_o = bus.m_cyc_i[0] & bus.m_stb_i[0];
      bus.s_we_o  = bus.m_we_i[0];
      bus.s_adr_o = bus.m_adr_i[31:0];
      bus.s_dat_o = bus.m_dat_i[31:0];
      bus.s_sel_o = bus.m_sel_i[3:0];
      bus.s_cti_o = bus.m_cti_i[2:0];
      bus.s_bte_o = bus.m_bte_i[1:0];
    end else if (w_own1) begin
      bus.s_cyc_o = bus.m_cyc_i[1];
      bus.s_stb_o = bus.m_cyc_i[1] & bus.m_stb_i[1];
      bus.s_we_o  = bus.m_we_i[1];
      bus.s_adr_o = bus.m_adr_i[63:32];
      bus.s_dat_o = bus.m_dat_i[63:32];
      bus.s_sel_o = bus.m_sel_i[7:4];
      bus.s_cti_o = bus.m_cti_i[5:3];
      bus.s_bte_o = bus.m_bte_i[3:2];
    end
  end

  // A real slave termination in the timeout cycle wins over the forced error.
  assign w_term    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign w_stall   = bus.s_stb_o & ~w_term;
  assign w_timeout = w_stall & (r_wd_cnt == TIMEOUT_CNT);
  assign timeout_o = w_timeout;

  always_comb begin
    w_wd_cnt_nxt = '0;
    if (w_stall && !w_timeout) begin
      w_wd_cnt_nxt = (r_wd_cnt == CNT_MAX) ? r_wd_cnt : r_wd_cnt + CNT_W'(1);
    end
  end

  assign bus.m_ack_o = grant_o & {2{bus.s_ack_i}};
  assign bus.m_err_o = grant_o & {2{bus.s_err_i | w_timeout}};
  assign bus.m_rty_o = grant_o & {2{bus.s_rty_i}};
  assign bus.m_dat_o = {2{bus.s_dat_i}};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed and random stimulus for wb_arbiter_2m, checked every cycle against
// an ownership/wait-count model plus literal expectations for key scenarios.
module tb_wb_arbiter_2m;
  localparam int TO = 255;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;

  int n_checks = 0;
  int n_err    = 0;
  int scen     = 0;
  int tcyc     = 0;
  int rem [2];

  // model state: owner -1 = idle
  int mo_owner = -1;
  int mo_last  = 1;
  int mo_wait  = 0;
  bit mo_valid = 0;

  wb_arbiter_2m_if bus ();

  wb_arbiter_2m #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .grant_o  (grant),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s (scen %0d cyc %0d): got %h expected %h", nm, scen, tcyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int x;
    bit e_cyc, e_stb, e_we, stall, to;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic [1:0]  e_bte, e_grant, e_ack, e_err, e_rty;
    stall = 1'b0;
    to    = 1'b0;
    if (mo_valid) begin
      x = mo_owner;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
      e_sel = '0; e_cti = '0; e_bte = '0; e_grant = 2'b00;
      e_ack = 2'b00; e_err = 2'b00; e_rty = 2'b00;
      if (x >= 0) begin
        e_cyc   = bus.m_cyc_i[x];
        e_stb   = bus.m_cyc_i[x] & bus.m_stb_i[x];
        e_we    = bus.m_we_i[x];
        e_adr   = bus.m_adr_i[x*32 +: 32];
        e_dat   = bus.m_dat_i[x*32 +: 32];
        e_sel   = bus.m_sel_i[x*4 +: 4];
        e_cti   = bus.m_cti_i[x*3 +: 3];
        e_bte   = bus.m_bte_i[x*2 +: 2];
        e_grant = (x == 0) ? 2'b01 : 2'b10;
      end
      stall = e_stb && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
      to    = stall && (mo_wait == TO);
      if (x >= 0) begin
        e_ack[x] = bus.s_ack_i;
        e_err[x] = bus.s_err_i | to;
        e_rty[x] = bus.s_rty_i;
      end
      chk("grant", 64'(grant), 64'(e_grant));
      chk("s_ctrl", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_cti_o, bus.s_bte_o}),
          64'({e_cyc, e_stb, e_we, e_sel, e_cti, e_bte}));
      chk("s_adr_dat", {bus.s_adr_o, bus.s_dat_o}, {e_adr, e_dat});
      chk("m_resp", 64'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 64'({e_ack, e_err, e_rty}));
      chk("m_dat", bus.m_dat_o, {bus.s_dat_i, bus.s_dat_i});
      chk("timeout", 64'(timeout), 64'(to));

      // literal expectations for the directed scenarios
      case (scen)
        0: if (tcyc == 1) begin
          chk("rst_grant", 64'(grant), 64'h0);
          chk("rst_sbus", 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_cti_o, bus.s_bte_o}), 64'h0);
          chk("rst_mresp", 64'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o, timeout}), 64'h0);
        end
        1: begin
          if (tcyc == 1) chk("tie_grant_c1", 64'(grant), 64'h1);
          if (tcyc == 4) chk("drop_scyc_c4", 64'({grant, bus.s_cyc_o, bus.s_stb_o}), 64'b0100);
          if (tcyc == 5) chk("idle_c5", 64'(grant), 64'h0);
          if (tcyc == 6) chk("rr_grant_c6", 64'(grant), 64'h2);
        end
        2: if (tcyc == 3) begin
          chk("rd_ack", 64'(bus.m_ack_o), 64'h1);
          chk("rd_dat", bus.m_dat_o, 64'hDEADBEEF_DEADBEEF);
          chk("rd_adr", 64'(bus.s_adr_o), 64'h1000);
        end
        3: begin
          if (tcyc >= 2 && tcyc <= 5) chk("burst_ack", 64'({grant, bus.m_ack_o}), 64'b1010);
          if (tcyc == 5) chk("burst_cti", 64'(bus.s_cti_o), 64'h7);
          if (tcyc == 6) chk("burst_rel_c6", 64'(grant), 64'h2);
          if (tcyc == 7) chk("burst_idle_c7", 64'(grant), 64'h0);
          if (tcyc == 8) chk("burst_next_c8", 64'(grant), 64'h1);
        end
        4: begin
          if (tcyc == 255) chk("wd_c255", 64'({timeout, bus.m_err_o}), 64'h0);
          if (tcyc == 256) chk("wd_c256", 64'({grant, timeout, bus.m_err_o}), 64'b10110);
          if (tcyc == 257) chk("wd_c257", 64'({grant, timeout, bus.m_err_o}), 64'b10000);
        end
        5: begin
          if (tcyc == 256) chk("wd_ack_wins", 64'({bus.m_ack_o, bus.m_err_o, timeout}), 64'b01000);
          if (tcyc == 257) chk("wd_ack_after", 64'({bus.m_err_o, timeout}), 64'h0);
        end
        6: begin
          if (tcyc == 4) chk("rst_abort", 64'({grant, bus.s_cyc_o, bus.m_ack_o}), 64'h0);
          if (tcyc == 6) chk("rst_tie_p0", 64'(grant), 64'h1);
        end
        default: ;
      endcase
    end

    if (rst) begin
      mo_owner = -1;
      mo_last  = 1;
      mo_wait  = 0;
      mo_valid = 1'b1;
    end else if (mo_valid) begin
      mo_wait = (stall && !to) ? mo_wait + 1 : 0;
      if (mo_owner < 0) begin
        if (bus.m_cyc_i == 2'b11) mo_owner = 1 - mo_last;
        else if (bus.m_cyc_i[0]) mo_owner = 0;
        else if (bus.m_cyc_i[1]) mo_owner = 1;
        if (mo_owner >= 0) mo_last = mo_owner;
      end else if (!bus.m_cyc_i[mo_owner]) begin
        mo_owner = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tcyc = tcyc + 1;
  endtask

  task automatic start(input int id);
    scen = id;
    tcyc = 0;
  endtask

  task automatic clear_all();
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.m_cti_i = '0; bus.m_bte_i = '0;
    bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0; bus.s_dat_i = '0;
  endtask

  task automatic set_port(input int p, input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    bus.m_cyc_i[p]          = cyc;
    bus.m_stb_i[p]          = stb;
    bus.m_we_i[p]           = we;
    bus.m_adr_i[p*32 +: 32] = adr;
    bus.m_dat_i[p*32 +: 32] = dat;
    bus.m_sel_i[p*4 +: 4]   = sel;
    bus.m_cti_i[p*3 +: 3]   = cti;
    bus.m_bte_i[p*2 +: 2]   = bte;
  endtask

  task automatic gap(input int n);
    start(99);
    clear_all();
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    start(0);
    repeat (3) step();

    // tie after reset goes to port 0, then round-robin to port 1
    start(1);
    rst = 1'b0;
    set_port(0, 1, 1, 0, 32'h10, 32'h0, 4'hF, 3'b000, 2'b00);
    set_port(1, 1, 1, 1, 32'h20, 32'h55, 4'hF, 3'b000, 2'b00);
    repeat (4) step();
    set_port(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    repeat (3) step();
    gap(3);

    // port 0 single read
    start(2);
    set_port(0, 1, 1, 0, 32'h0000_1000, 32'h0, 4'hF, 3'b000, 2'b00);
    repeat (3) step();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEADBEEF;
    step();
    bus.s_ack_i = 1'b0;
    set_port(0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    step();
    gap(3);

    // port 1 four-beat burst while port 0 waits
    start(3);
    set_port(0, 1, 1, 0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00);
    set_port(1, 1, 1, 0, 32'h2000, 32'h0, 4'hF, 3'b010, 2'b00);
    step();
    for (int b = 0; b < 4; b++) begin
      step();
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'hA000 + 32'(b);
      bus.m_adr_i[63:32] = 32'h2000 + 32'(4 * b);
      if (b == 3) bus.m_cti_i[5:3] = 3'b111;
    end
    step();
    bus.s_ack_i = 1'b0;
    set_port(1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    repeat (3) step();
    gap(3);

    // port 1 write that the slave never answers
    start(4);
    set_port(1, 1, 1, 1, 32'h3000, 32'h1234_5678, 4'hF, 3'b000, 2'b00);
    repeat (260) step();
    gap(3);

    // slave ack lands in the cycle the watchdog would fire
    start(5);
    set_port(0, 1, 1, 0, 32'h4000, 32'h0, 4'hF, 3'b000, 2'b00);
    repeat (256) step();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h0BAD_F00D;
    step();
    bus.s_ack_i = 1'b0;
    step();
    gap(3);

    // reset in the middle of a port 0 burst
    start(6);
    set_port(0, 1, 1, 0, 32'h5000, 32'h0, 4'hF, 3'b010, 2'b00);
    step();
    step();
    bus.s_ack_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    bus.s_ack_i = 1'b0;
    set_port(1, 1, 1, 0, 32'h6000, 32'h0, 4'hF, 3'b000, 2'b00);
    repeat (2) step();
    gap(3);

    // random masters, slave and occasional reset
    start(7);
    rem[0] = 0;
    rem[1] = 0;
    repeat (3000) begin
      for (int p = 0; p < 2; p++) begin
        if (rem[p] == 0 && ($urandom % 4 == 0)) rem[p] = $urandom_range(1, 10);
        if (rem[p] > 0) begin
          set_port(p, 1'b1, ($urandom % 4) != 0, 1'($urandom), $urandom, $urandom,
                   4'($urandom), 3'($urandom), 2'($urandom));
          rem[p] = rem[p] - 1;
        end else begin
          set_port(p, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
        end
      end
      bus.s_ack_i = ($urandom % 3) == 0;
      bus.s_err_i = ($urandom % 16) == 0;
      bus.s_rty_i = ($urandom % 16) == 0;
      bus.s_dat_i = $urandom;
      rst = ($urandom % 400) == 0;
      step();
    end
    rst = 1'b0;
    gap(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
